// File: rtl/mro_pkg.sv
// Shared defaults, width helper and vector type for the age-order tracker.
package mro_pkg;
  localparam int MRO_ENTRIES_DEF = 8;
  localparam int MRO_NUM_SEL_DEF = 2;

  // A slot index needs at least one bit, even when there is a single slot.
  function automatic int mro_id_w(input int entries);
    return (entries > 1) ? $clog2(entries) : 1;
  endfunction

  typedef logic [MRO_ENTRIES_DEF-1:0] t_mro_vec;
endpackage

// File: rtl/mro_oldest_sel.sv
// One oldest-select channel.
// Selects the valid, masked slot that no other candidate is older than.
module mro_oldest_sel
  import mro_pkg::*;
#(
  parameter int ENTRIES = MRO_ENTRIES_DEF,
  parameter int ID_W    = mro_id_w(ENTRIES)
) (
  input  logic [ENTRIES-1:0]              valid,
  input  logic [ENTRIES-1:0][ENTRIES-1:0] older,
  input  logic [ENTRIES-1:0]              sel_mask,
  output logic [ENTRIES-1:0]              oldest,
  output logic                            oldest_vld,
  output logic [ID_W-1:0]                 oldest_id
);
  logic [ENTRIES-1:0] cand;

  assign cand       = valid & sel_mask;
  assign oldest_vld = |cand;

  genvar gi, gj;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_slot
      // Column gi of the matrix: which slots are older than slot gi.
      logic [ENTRIES-1:0] older_than_i;
      for (gj = 0; gj < ENTRIES; gj++) begin : g_col
        assign older_than_i[gj] = older[gj][gi];
      end
      assign oldest[gi] = cand[gi] && !(|(cand & older_than_i));
    end
  endgenerate

  // The age matrix is a total order over valid slots, so oldest is one-hot.
  always_comb begin
    oldest_id = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (oldest[i]) begin
        oldest_id = oldest_id | ID_W'(i);
      end
    end
  end
endmodule

// File: rtl/mro_age_tracker.sv
// Age-order tracker: lowest-free allocation, full age matrix, multi-slot
// retirement and NUM_SEL independent oldest-matching queries per cycle.
module mro_age_tracker
  import mro_pkg::*;
#(
  parameter int ENTRIES = MRO_ENTRIES_DEF,
  parameter int NUM_SEL = MRO_NUM_SEL_DEF,
  parameter int ID_W    = mro_id_w(ENTRIES)
) (
  input  logic                      Clk,
  input  logic                      Rst,
  input  logic                      AllocReq,
  output logic                      AllocGnt,
  output logic [ENTRIES-1:0]        AllocId,
  input  logic [ENTRIES-1:0]        Dealloc,
  input  logic [NUM_SEL*ENTRIES-1:0] SelMask,
  output logic [NUM_SEL*ENTRIES-1:0] Oldest,
  output logic [NUM_SEL-1:0]        OldestVld,
  output logic [NUM_SEL*ID_W-1:0]   OldestId,
  output logic [ID_W:0]             Occupancy,
  output logic                      Full,
  output logic                      Empty,
  output logic                      ErrDealloc
);
  logic [ENTRIES-1:0]              valid_reg, valid_next;
  logic [ENTRIES-1:0][ENTRIES-1:0] older_reg, older_next;
  logic [ID_W:0]                   occupancy_reg, occupancy_next;
  logic                            err_reg, err_next;

  logic [ENTRIES-1:0] alloc_onehot;
  logic [ENTRIES-1:0] alloc_vec;
  logic [ENTRIES-1:0] dealloc_eff;
  logic [ID_W:0]      retired;
  logic               gnt;
  logic               full;

  // Lowest-index free slot, taken from pre-edge state only.
  always_comb begin
    alloc_onehot = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_reg[i]) begin
        alloc_onehot = '0;
        alloc_onehot[i] = 1'b1;
      end
    end
  end

  assign full        = (occupancy_reg == (ID_W+1)'(ENTRIES));
  assign gnt         = AllocReq && !full && !Rst;
  assign alloc_vec   = gnt ? alloc_onehot : '0;
  assign dealloc_eff = Dealloc & valid_reg;

  always_comb begin
    retired = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      retired = retired + (ID_W+1)'(dealloc_eff[i]);
    end
  end

  assign valid_next     = (valid_reg & ~dealloc_eff) | alloc_vec;
  assign occupancy_next = occupancy_reg + (ID_W+1)'(gnt) - retired;
  assign err_next       = err_reg || (|(Dealloc & ~valid_reg));

  genvar gi, gj;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_row
      for (gj = 0; gj < ENTRIES; gj++) begin : g_col
        if (gi == gj) begin : g_diag
          assign older_next[gi][gj] = 1'b0;
        end else begin : g_off
          // New slot is younger than every survivor; retired slots drop out.
          assign older_next[gi][gj] =
            (dealloc_eff[gi] || dealloc_eff[gj] || alloc_vec[gi]) ? 1'b0 :
            alloc_vec[gj] ? (valid_reg[gi] && !Dealloc[gi]) :
            older_reg[gi][gj];
        end
      end
    end
  endgenerate

  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_reg     <= '0;
      older_reg     <= '0;
      occupancy_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      valid_reg     <= valid_next;
      older_reg     <= older_next;
      occupancy_reg <= occupancy_next;
      err_reg       <= err_next;
    end
  end

  // Any two valid slots are strictly ordered; nothing is older than itself.
  always @(posedge Clk) begin
    if (!Rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        for (int j = 0; j < ENTRIES; j++) begin
          if (i == j) begin
            assert (!older_reg[i][j]);
          end else if (valid_reg[i] && valid_reg[j]) begin
            assert (older_reg[i][j] ^ older_reg[j][i]);
          end
        end
      end
    end
  end

  assign AllocGnt   = gnt;
  assign AllocId    = alloc_onehot;
  assign Occupancy  = occupancy_reg;
  assign Full       = full;
  assign Empty      = (occupancy_reg == '0);
  assign ErrDealloc = err_reg;

  generate
    for (gi = 0; gi < NUM_SEL; gi++) begin : g_sel
      mro_oldest_sel #(
        .ENTRIES (ENTRIES),
        .ID_W    (ID_W)
      ) u_sel (
        .valid      (valid_reg),
        .older      (older_reg),
        .sel_mask   (SelMask[gi*ENTRIES +: ENTRIES]),
        .oldest     (Oldest[gi*ENTRIES +: ENTRIES]),
        .oldest_vld (OldestVld[gi]),
        .oldest_id  (OldestId[gi*ID_W +: ID_W])
      );
    end
  endgenerate
endmodule

// File: tb/tb_mro_age_tracker.sv
// Randomised scoreboard bench for mro_age_tracker against an allocation-order
// list model (ENTRIES=8, NUM_SEL=2).
module tb_mro_age_tracker;
  import mro_pkg::*;

  localparam int E  = 8;
  localparam int NS = 2;
  localparam int IW = 3;

  logic              clk;
  logic              rst;
  logic              alloc_req;
  logic              alloc_gnt;
  logic [E-1:0]      alloc_id;
  logic [E-1:0]      dealloc;
  logic [NS*E-1:0]   sel_mask;
  logic [NS*E-1:0]   oldest;
  logic [NS-1:0]     oldest_vld;
  logic [NS*IW-1:0]  oldest_id;
  logic [IW:0]       occupancy;
  logic              full;
  logic              empty;
  logic              err_dealloc;

  mro_age_tracker #(.ENTRIES(E), .NUM_SEL(NS)) dut (
    .Clk        (clk),
    .Rst        (rst),
    .AllocReq   (alloc_req),
    .AllocGnt   (alloc_gnt),
    .AllocId    (alloc_id),
    .Dealloc    (dealloc),
    .SelMask    (sel_mask),
    .Oldest     (oldest),
    .OldestVld  (oldest_vld),
    .OldestId   (oldest_id),
    .Occupancy  (occupancy),
    .Full       (full),
    .Empty      (empty),
    .ErrDealloc (err_dealloc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit              gnt;
    bit              check_id;
    logic [E-1:0]    alloc_id;
    int              occ;
    bit              full;
    bit              empty;
    bit              err;
    logic [NS*E-1:0] oldest;
    logic [NS-1:0]   vld;
    logic [NS*IW-1:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   age_q[$];   // slot numbers, oldest first
  bit   err_m;
  int   checks;
  int   failures;
  int   txn;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s txn=%0d actual=%0h expected=%0h", nm, txn, act, exp);
    end
  endtask

  function automatic t_mro_vec model_valid();
    t_mro_vec v = '0;
    foreach (age_q[k]) v[age_q[k]] = 1'b1;
    return v;
  endfunction

  // Drive one cycle, queue the expected response, then advance the model past the edge.
  task automatic step(input bit r, input bit areq, input logic [E-1:0] dl, input logic [NS*E-1:0] mask);
    exp_t     e;
    t_mro_vec vm;
    int       free_slot;
    int       nq[$];
    @(posedge clk);
    #1;
    rst = r; alloc_req = areq; dealloc = dl; sel_mask = mask;
    vm = model_valid();
    free_slot = -1;
    for (int i = E - 1; i >= 0; i--) if (!vm[i]) free_slot = i;
    e.occ      = age_q.size();
    e.full     = (age_q.size() == E);
    e.empty    = (age_q.size() == 0);
    e.err      = err_m;
    e.gnt      = areq && !e.full && !r;
    e.check_id = !e.full;
    e.alloc_id = e.full ? '0 : (E'(1) << free_slot);
    e.oldest   = '0;
    e.vld      = '0;
    e.id       = '0;
    for (int c = 0; c < NS; c++) begin
      foreach (age_q[k]) begin
        if (!e.vld[c] && mask[c*E + age_q[k]]) begin
          e.vld[c] = 1'b1;
          e.oldest[c*E + age_q[k]] = 1'b1;
          e.id[c*IW +: IW] = IW'(age_q[k]);
        end
      end
    end
    sb_q.push_back(e);
    if (r) begin
      age_q.delete();
      err_m = 1'b0;
    end else begin
      if ((dl & ~vm) != '0) err_m = 1'b1;
      foreach (age_q[k]) if (!dl[age_q[k]]) nq.push_back(age_q[k]);
      if (e.gnt) nq.push_back(free_slot);
      age_q = nq;
    end
  endtask

  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      txn++;
      chk("alloc_gnt", 32'(alloc_gnt), 32'(e.gnt));
      if (e.check_id) chk("alloc_id", 32'(alloc_id), 32'(e.alloc_id));
      chk("occupancy", 32'(occupancy), 32'(e.occ));
      chk("full", 32'(full), 32'(e.full));
      chk("empty", 32'(empty), 32'(e.empty));
      chk("err_dealloc", 32'(err_dealloc), 32'(e.err));
      chk("oldest", 32'(oldest), 32'(e.oldest));
      chk("oldest_vld", 32'(oldest_vld), 32'(e.vld));
      chk("oldest_id", 32'(oldest_id), 32'(e.id));
      $display("txn %0d gnt=%0b id=%02h occ=%0d old=%04h vld=%02b err=%0b",
               txn, alloc_gnt, alloc_id, occupancy, oldest, oldest_vld, err_dealloc);
    end
  end

  initial begin
    t_mro_vec vm;
    logic [E-1:0] dl;
    checks = 0; failures = 0; txn = 0; err_m = 1'b0;
    rst = 1'b1; alloc_req = 1'b0; dealloc = '0; sel_mask = '0;
    repeat (2) @(posedge clk);

    // Lowest-free allocation order and oldest over full mask.
    step(1, 0, 8'h00, 16'h0000);
    repeat (3) step(0, 1, 8'h00, 16'h00FF);
    step(0, 0, 8'h00, 16'h00FF);

    // Reused slot 0 becomes youngest.
    step(1, 0, 8'h00, 16'h0000);
    repeat (4) step(0, 1, 8'h00, 16'h0000);
    step(0, 0, 8'h01, 16'h0003);
    step(0, 1, 8'h00, 16'h0003);
    step(0, 0, 8'h00, 16'h0003);

    // Full: request refused while slot 7 retires, then slot 7 is offered.
    step(1, 0, 8'h00, 16'h0000);
    repeat (8) step(0, 1, 8'h00, 16'hFFFF);
    step(0, 1, 8'h80, 16'hFFFF);
    step(0, 0, 8'h00, 16'hFFFF);

    // Partial masks on two channels, empty mask on channel 1.
    step(1, 0, 8'h00, 16'h0000);
    repeat (4) step(0, 1, 8'h00, 16'h0000);
    step(0, 0, 8'h00, 16'h000C);

    // Illegal deallocation of slot 4 is sticky and leaves state alone.
    step(0, 0, 8'h10, 16'h00FF);
    step(0, 0, 8'h00, 16'h00FF);
    step(0, 0, 8'h00, 16'h00FF);

    // Reset overrides alloc and dealloc.
    step(1, 1, 8'h0F, 16'hFFFF);
    step(0, 0, 8'h00, 16'hFFFF);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      vm = model_valid();
      dl = '0;
      if ($urandom_range(0, 99) < 40) dl = 8'($urandom) & vm & 8'($urandom);
      if ($urandom_range(0, 99) < 2) dl = 8'($urandom);
      step(($urandom_range(0, 299) == 0), ($urandom_range(0, 2) != 0), dl, 16'($urandom));
    end
    step(0, 0, 8'h00, 16'h0000);

    for (int k = 0; k < 10 && sb_q.size() > 0; k++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d required=0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
